// File: rtl/dff_bank_pkg.sv
// Shared constants and helpers for the round-robin drained capture bank.
package dff_bank_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, with wrap.
import dff_bank_pkg::*;

module rr_arbiter #(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IDXW     = clog2_min1(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDXW-1:0]     ptr,
    input  logic                en,
    output logic [CHANNELS-1:0] gnt,
    output logic [IDXW-1:0]     gnt_idx,
    output logic                any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        // Scan farthest-first so the nearest requester after ptr is the last writer.
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(ptr) + k) % CHANNELS;
            if (req[idx]) begin
                gnt_idx = IDXW'(idx);
                any     = 1'b1;
            end
        end
        gnt[gnt_idx] = en & any;
    end

endmodule

// File: rtl/dff_bank_rr_drain.sv
// Multi-channel capture bank with pending/overrun tracking and a round-robin drain port.
// Optional macro DFF_BANK_PARITY_EN adds out_par, the XOR of the drained word.
import dff_bank_pkg::*;

module dff_bank_rr_drain #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int IDXW    = clog2_min1(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       pend,
    output logic [CHANNELS-1:0]       overrun,
    input  logic                      ovr_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
`ifdef DFF_BANK_PARITY_EN
    output logic                      out_par,
`endif
    output logic [IDXW-1:0]           out_ch
);

    // Handshake: a word transfers on any edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_valid/out_data/out_ch do not change.

    logic [WIDTH-1:0]    regs [CHANNELS];
    logic [IDXW-1:0]     ptr;
    logic                free;
    logic [CHANNELS-1:0] gnt;
    logic [IDXW-1:0]     gnt_idx;
    logic                any;
    logic [WIDTH-1:0]    sel_word;

    assign free     = ~out_valid | out_ready;
    assign sel_word = regs[gnt_idx];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_q
        assign q[i*WIDTH +: WIDTH] = regs[i];
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDXW     (IDXW)
    ) u_arb (
        .req     (pend),
        .ptr     (ptr),
        .en      (free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) regs[i] <= '0;
            pend      <= '0;
            overrun   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= IDXW'(CHANNELS - 1);
`ifdef DFF_BANK_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ld[i]) regs[i] <= d[i*WIDTH +: WIDTH];
            end
            // A reload on the granting edge keeps the channel pending for its new word.
            pend    <= (pend & ~gnt) | ld;
            // Setting beats clearing when both land on one edge.
            overrun <= (overrun & ~{CHANNELS{ovr_clr}}) | (ld & pend & ~gnt);
            if (free) begin
                if (any) begin
                    out_valid <= 1'b1;
                    out_data  <= sel_word;
                    out_ch    <= gnt_idx;
                    ptr       <= gnt_idx;
`ifdef DFF_BANK_PARITY_EN
                    out_par   <= ^sel_word;
`endif
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
